// File: rtl/exe_stage.sv
// ----------------------------------------------------------------------------
// exe_stage
//   Execute stage of the multi-cycle CPU, directly upstream of memory access.
//   Single-cycle ALU ops complete in CALC. MUL runs in the MUL state as an
//   iterative unsigned shift-add, keeping the low DATA_W bits of the product.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   exeStart      one-cycle request to execute the operands presented now
//   aluOp         0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 SLL 6 SRL 7 SRA 8 SLT 9 SLTU
//                 10 MUL 11 PASSB 12 BRTGT, 13-15 reserved (result 0)
//   aluSrcB       0: B = regBOut, 1: B = immOut
//   condType      0 none, 1 BEQ, 2 BNE, 3 JUMP
//   npcOut, regAOut, regBOut, immOut   operands
//   aluOOut       registered ALU result
//   condOut       registered branch-taken flag
//   exeBusy       high while the FSM is not IDLE
//   exeDone       one-cycle pulse: aluOOut/condOut just updated
//
// Handshake: exeStart is accepted only when exeBusy is low (state IDLE);
//   requests while busy are dropped, not queued. Every accepted request
//   yields exactly one exeDone pulse (unless reset intervenes), which is
//   also the cycle the FSM is back in IDLE, so a new exeStart may be given
//   in the same cycle exeDone is high.
// ----------------------------------------------------------------------------
module exe_stage #(
   parameter int DATA_W = 32,
   parameter int SH_W   = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              exeStart,
   input  logic [3:0]        aluOp,
   input  logic              aluSrcB,
   input  logic [1:0]        condType,
   input  logic [DATA_W-1:0] npcOut,
   input  logic [DATA_W-1:0] regAOut,
   input  logic [DATA_W-1:0] regBOut,
   input  logic [DATA_W-1:0] immOut,
   output logic [DATA_W-1:0] aluOOut,
   output logic              condOut,
   output logic              exeBusy,
   output logic              exeDone
);

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_AND   = 4'd2;
   localparam logic [3:0] OP_OR    = 4'd3;
   localparam logic [3:0] OP_XOR   = 4'd4;
   localparam logic [3:0] OP_SLL   = 4'd5;
   localparam logic [3:0] OP_SRL   = 4'd6;
   localparam logic [3:0] OP_SRA   = 4'd7;
   localparam logic [3:0] OP_SLT   = 4'd8;
   localparam logic [3:0] OP_SLTU  = 4'd9;
   localparam logic [3:0] OP_MUL   = 4'd10;
   localparam logic [3:0] OP_PASSB = 4'd11;
   localparam logic [3:0] OP_BRTGT = 4'd12;

   localparam logic [1:0] CT_NONE = 2'd0;
   localparam logic [1:0] CT_BEQ  = 2'd1;
   localparam logic [1:0] CT_BNE  = 2'd2;
   localparam logic [1:0] CT_JUMP = 2'd3;

   localparam logic [SH_W-1:0] CNT_LAST = SH_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_MUL  = 2'd2
   } state_t;

   state_t state, state_nxt;

   // latched operands
   logic [3:0]        op_q;
   logic [1:0]        ct_q;
   logic [DATA_W-1:0] npc_q, a_q, b_q, regb_q;

   // multiplier working registers
   logic [DATA_W-1:0] acc, mcand, mplr;
   logic [SH_W-1:0]   cnt;
   logic              mul_fin;

   logic [DATA_W-1:0] b_sel;
   logic [DATA_W-1:0] alu_res;
   logic              cond_res;
   logic [SH_W-1:0]   shamt;

   assign b_sel = aluSrcB ? immOut : regBOut;
   assign shamt = b_q[SH_W-1:0];

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // FSM next state and status output
   always_comb begin
      state_nxt = state;
      exeBusy   = (state != ST_IDLE);
      case (state)
         ST_IDLE: if (exeStart) state_nxt = (aluOp == OP_MUL) ? ST_MUL : ST_CALC;
         ST_CALC: state_nxt = ST_IDLE;
         ST_MUL:  if (mul_fin) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // single-cycle ALU on the latched operands
   always_comb begin
      alu_res = '0;
      case (op_q)
         OP_ADD:   alu_res = a_q + b_q;
         OP_SUB:   alu_res = a_q - b_q;
         OP_AND:   alu_res = a_q & b_q;
         OP_OR:    alu_res = a_q | b_q;
         OP_XOR:   alu_res = a_q ^ b_q;
         OP_SLL:   alu_res = a_q << shamt;
         OP_SRL:   alu_res = a_q >> shamt;
         OP_SRA:   alu_res = $unsigned($signed(a_q) >>> shamt);
         OP_SLT:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
         OP_SLTU:  alu_res = {{(DATA_W-1){1'b0}}, (a_q < b_q)};
         OP_PASSB: alu_res = b_q;
         OP_BRTGT: alu_res = npc_q + (b_q << 2);
         default:  alu_res = '0;
      endcase
   end

   // branch condition always compares against register B, never the immediate;
   // reserved opcodes force it low
   always_comb begin
      cond_res = 1'b0;
      if (op_q <= OP_BRTGT) begin
         case (ct_q)
            CT_NONE: cond_res = 1'b0;
            CT_BEQ:  cond_res = (a_q == regb_q);
            CT_BNE:  cond_res = (a_q != regb_q);
            CT_JUMP: cond_res = 1'b1;
            default: cond_res = 1'b0;
         endcase
      end
   end

   // datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q    <= '0;
         ct_q    <= '0;
         npc_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         regb_q  <= '0;
         acc     <= '0;
         mcand   <= '0;
         mplr    <= '0;
         cnt     <= '0;
         mul_fin <= 1'b0;
         aluOOut <= '0;
         condOut <= 1'b0;
         exeDone <= 1'b0;
      end else begin
         exeDone <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (exeStart) begin
                  op_q    <= aluOp;
                  ct_q    <= condType;
                  npc_q   <= npcOut;
                  a_q     <= regAOut;
                  b_q     <= b_sel;
                  regb_q  <= regBOut;
                  acc     <= '0;
                  mcand   <= regAOut;
                  mplr    <= b_sel;
                  cnt     <= '0;
                  mul_fin <= 1'b0;
               end
            end
            ST_CALC: begin
               aluOOut <= alu_res;
               condOut <= cond_res;
               exeDone <= 1'b1;
            end
            ST_MUL: begin
               // DATA_W iteration cycles (cnt 0..DATA_W-1), then one
               // write-back cycle that publishes acc and returns to IDLE
               if (!mul_fin) begin
                  if (mplr[0]) acc <= acc + mcand;
                  mcand <= mcand << 1;
                  mplr  <= mplr >> 1;
                  if (cnt == CNT_LAST) mul_fin <= 1'b1;
                  else                 cnt     <= cnt + 1'b1;
               end else begin
                  aluOOut <= acc;
                  condOut <= 1'b0;
                  exeDone <= 1'b1;
                  mul_fin <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
